// File: rtl/nibble_add_arbiter.sv
// Round-robin arbiter sharing one 4-bit adder between two byte-add requesters (build option NIBADD_SUB_EN adds sub0/sub1 subtract).
// Latency: gnt the cycle after the request edge, done 2 cycles after the grant edge; one operation per 3 cycles.
// Backpressure: req is a held level; requests seen during LO/HI wait for IDLE and are never queued.
module nibble_add_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
`ifdef NIBADD_SUB_EN
    input  logic       sub0,
    input  logic       sub1,
`endif
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [8:0] q
);

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic       id;
    } op_t;

    state_t     state, state_nxt;
    op_t        op, op_nxt;
    logic       ptr, ptr_nxt;
    logic       win;
    logic       gnt0_nxt, gnt1_nxt, done_nxt;
    logic       s0, s1;
    logic [3:0] sum_lo;
    logic       carry;
    logic [7:0] b_eff;
    logic [3:0] nib_a, nib_b;
    logic       nib_cin;
    logic [4:0] nib_sum;

`ifdef NIBADD_SUB_EN
    assign s0 = sub0;
    assign s1 = sub1;
`else
    assign s0 = 1'b0;
    assign s1 = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        ptr_nxt   = ptr;
        win       = ptr;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // a lone requester wins regardless of the pointer
                    win       = (req0 && req1) ? ptr : req1;
                    op_nxt.id = win;
                    op_nxt.a  = win ? a1 : a0;
                    op_nxt.b  = win ? b1 : b0;
                    op_nxt.s  = win ? s1 : s0;
                    ptr_nxt   = ~win;
                    gnt0_nxt  = ~win;
                    gnt1_nxt  = win;
                    state_nxt = LO;
                end
            end
            LO:      state_nxt = HI;
            HI: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op    <= '0;
            ptr   <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
            ptr   <= ptr_nxt;
            gnt0  <= gnt0_nxt;
            gnt1  <= gnt1_nxt;
            done  <= done_nxt;
        end
    end

    // Shared nibble adder: subtract is A + ~B + 1, the +1 entering as the low-pass carry-in
    assign b_eff   = op.s ? ~op.b : op.b;
    assign nib_a   = (state == HI) ? op.a[7:4]  : op.a[3:0];
    assign nib_b   = (state == HI) ? b_eff[7:4] : b_eff[3:0];
    assign nib_cin = (state == HI) ? carry      : op.s;
    assign nib_sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, nib_cin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_lo  <= 4'h0;
            carry   <= 1'b0;
            q       <= 9'h000;
            done_id <= 1'b0;
        end else if (state == LO) begin
            sum_lo <= nib_sum[3:0];
            carry  <= nib_sum[4];
        end else if (state == HI) begin
            q       <= {nib_sum, sum_lo};
            done_id <= op.id;
        end
    end

endmodule

// File: tb/tb_nibble_add_arbiter.sv
// Scoreboard bench for nibble_add_arbiter: expected {id, q} queued at request time, checked at done.
module tb_nibble_add_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       sub0 = 1'b0, sub1 = 1'b0;
    logic       gnt0, gnt1, busy, done, done_id;
    logic [8:0] q;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_gnt = 0;
    int         g_prev;
    bit         prev_done = 1'b0;
    logic [9:0] sb[$];
    logic [9:0] e;

    nibble_add_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
`ifdef NIBADD_SUB_EN
        .sub0(sub0), .sub1(sub1),
`endif
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .done(done), .done_id(done_id), .q(q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        if (s) return {1'b0, a} + {1'b0, ~b} + 9'd1;
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic wait_gnt(input bit id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((id ? gnt1 : gnt0) !== 1'b1) && n < 20);
        chk("gnt_wait", ((id ? gnt1 : gnt0) === 1'b1), 1);
        chk("gnt_excl", (id ? gnt0 : gnt1), 0);
    endtask

    task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b, input logic s);
        if (id) begin a1 = a; b1 = b; sub1 = s; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; sub0 = s; req0 = 1'b1; end
        sb.push_back({id, model(a, b, s)});
        wait_gnt(id);
        chk("busy_at_gnt", busy, 1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", sb.size(), 0);
        chk("idle_after_drain", busy, 0);
    endtask

    // Done monitor: pops the scoreboard and checks pulse rules and latency
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt0 || gnt1) last_gnt = cyc;
            if (done) begin
                chk("done_with_gnt", (gnt0 | gnt1), 0);
                chk("done_twice", prev_done, 0);
                chk("done_latency", cyc - last_gnt, 2);
                if (sb.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", done_id, e[9]);
                    chk("q", q, e[8:0]);
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        chk("rst_q", q, 0);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        @(negedge clk);
        rst = 1'b0;

        issue(1'b0, 8'h24, 8'h81, 1'b0);
        issue(1'b1, 8'h0d, 8'h8d, 1'b0);
        issue(1'b1, 8'hed, 8'h8c, 1'b0);
        drain();
        chk("q_held", q, 9'h179);

        // Both requesters held from reset: 0, 1, 0 at 3-cycle spacing
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a0 = 8'h11; b0 = 8'hf0; sub0 = 1'b0;
        a1 = 8'h99; b1 = 8'h77; sub1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        sb.push_back({1'b0, model(8'h11, 8'hf0, 1'b0)});
        sb.push_back({1'b1, model(8'h99, 8'h77, 1'b0)});
        sb.push_back({1'b0, model(8'h11, 8'hf0, 1'b0)});
        wait_gnt(1'b0);
        g_prev = cyc;
        wait_gnt(1'b1);
        chk("rr_gap1", cyc - g_prev, 3);
        g_prev = cyc;
        wait_gnt(1'b0);
        chk("rr_gap2", cyc - g_prev, 3);
        req0 = 1'b0; req1 = 1'b0;
        drain();

        // Reset mid-operation abandons it; held req0 is re-granted right after
        a0 = 8'h5a; b0 = 8'h33; req0 = 1'b1;
        wait_gnt(1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_q", q, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gnt0", gnt0, 0);
        @(negedge clk);
        chk("mid_rst_done", done, 0);
        rst = 1'b0;
        sb.push_back({1'b0, model(8'h5a, 8'h33, 1'b0)});
        @(negedge clk);
        chk("regrant", gnt0, 1);
        req0 = 1'b0;
        drain();

`ifdef NIBADD_SUB_EN
        issue(1'b0, 8'h76, 8'h3d, 1'b1);
        issue(1'b0, 8'h01, 8'h0d, 1'b1);
        drain();
`endif

        for (int i = 0; i < 8; i++) begin
            issue(i[0], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
`ifdef NIBADD_SUB_EN
                  1'($urandom_range(0, 1)));
`else
                  1'b0);
`endif
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
